// File: rtl/riscv_pipe_pkg.sv
// Shared RV32 pipeline constants: operand-forward select codes and control-bus bit layout.
// Control bus layout: {reg_write, mem_read, mem_write, alu_src, alu_op[3:0]}.
package riscv_pipe_pkg;
  localparam int CTRL_W = 8;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_gen.sv
// Purpose: operand-forward select for one source register (youngest producer wins, x0 never forwards).
// Latency: combinational.
// Backpressure: none; the caller decides when the select is captured.
module fwd_sel_gen
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (ex_valid && ex_reg_write && (ex_rd != '0) && (ex_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// Purpose: ID/EX register with load-use bubble insertion and registered forward selects.
// Latency: 1 cycle ID->EX. Backpressure: ex_ready low freezes the stage; id_ready drops on stall or load-use.
// Optional: define ID_EX_STALL_CNT_EN to add the saturating load-use bubble counter stall_cnt.
module id_ex_fwd_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [1:0]        id_rs_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);

  logic       lu;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  // Load in EX whose rd feeds a register the decode instruction actually reads.
  assign lu = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) && id_valid &&
              ((id_rs_used[0] && (id_rs1 == ex_rd)) || (id_rs_used[1] && (id_rs2 == ex_rd)));

  assign id_ready = flush || (ex_ready && !lu);

  fwd_sel_gen #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (id_rs1),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_ctrl[CTRL_REG_WRITE]),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (fwd_a_nxt)
  );

  fwd_sel_gen #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_ctrl[CTRL_REG_WRITE]),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (fwd_b_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      ex_fwd_a    <= FWD_REG;
      ex_fwd_b    <= FWD_REG;
    end else if (flush || (ex_ready && lu)) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_fwd_a <= FWD_REG;
      ex_fwd_b <= FWD_REG;
    end else if (ex_ready) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_fwd_a    <= fwd_a_nxt;
      ex_fwd_b    <= fwd_b_nxt;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Only real bubbles count: flush takes priority and a frozen EX never evaluates load-use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!flush && ex_ready && lu && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
